// File: rtl/iter_mult.sv
// iter_mult: multi-cycle shift-add multiplier, signed or unsigned, full 2*WIDTH product.
// Define ITER_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module iter_mult #(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             do_signed,
   input  logic             cancel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] mult_low,
   output logic [WIDTH-1:0] mult_high,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, state_next;
   logic [WIDTH-1:0]     mcand, mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;
   logic                 neg;

   logic                 accept;
   logic                 last_iter;
   logic [WIDTH-1:0]     a_mag, b_mag, mplier_next;
   logic [2*WIDTH-1:0]   addend, acc_next, product;

   // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1) without overflow.
   always_comb begin
      a_mag       = (do_signed && a[WIDTH-1]) ? -a : a;
      b_mag       = (do_signed && b[WIDTH-1]) ? -b : b;
      accept      = (state == IDLE) && in_valid && !cancel;
      addend      = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
      acc_next    = acc + addend;
      mplier_next = mplier >> 1;
      product     = neg ? -acc_next : acc_next;
`ifdef ITER_MULT_EARLY_TERM_EN
      last_iter   = (cnt == CNT_W'(WIDTH-1)) || (mplier_next == '0);
`else
      last_iter   = (cnt == CNT_W'(WIDTH-1));
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN: begin
            if (cancel)         state_next = IDLE;
            else if (last_iter) state_next = DONE;
         end
         DONE:    if (cancel || out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == RUN) || (state == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         mult_low  <= '0;
         mult_high <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= do_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (!cancel) begin
                  acc    <= acc_next;
                  mplier <= mplier_next;
                  cnt    <= cnt + CNT_W'(1);
                  if (last_iter) {mult_high, mult_low} <= product;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_mult.sv
// tb_iter_mult: scoreboard bench for iter_mult (WIDTH=8), random and directed operations
// against an integer-arithmetic reference model.
module tb_iter_mult;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         do_signed = 1'b0;
   logic         cancel = 1'b0;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] mult_low, mult_high;
   logic         busy;

   iter_mult #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .do_signed(do_signed), .cancel(cancel),
      .out_valid(out_valid), .out_ready(out_ready),
      .mult_low(mult_low), .mult_high(mult_high), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] prod;
      int             acc_cyc;
      int             lat;
   } exp_t;

   exp_t           sb[$];
   int             cyc = 0;
   int             total = 0;
   int             bad = 0;
   logic [2*W-1:0] last_prod = '0;
   logic [2*W-1:0] held = '0;
   logic           prev_ov = 1'b0;
   bit             rdy_rand = 1'b0;
   bit             rdy_force = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input bit s);
      int xi = int'(x);
      int yi = int'(y);
      if (s && x[W-1]) xi -= (1 << W);
      if (s && y[W-1]) yi -= (1 << W);
      return (2*W)'(xi * yi);
   endfunction

   function automatic int ref_lat(input logic [W-1:0] y, input bit s);
`ifdef ITER_MULT_EARLY_TERM_EN
      int m = (s && y[W-1]) ? (1 << W) - int'(y) : int'(y);
      int n = 0;
      while (m > 0) begin
         n++;
         m = m >> 1;
      end
      return (n < 1) ? 1 : n;
`else
      return W;
`endif
   endfunction

   // Monitor: checks each product when out_valid first rises, then its stability while held.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("product", {16'b0, mult_high, mult_low}, {16'b0, e.prod});
            chk("latency", cyc - e.acc_cyc, e.lat);
            chk("busy_in_done", {31'b0, busy}, 32'd1);
            held      = e.prod;
            last_prod = e.prod;
         end
      end else if (out_valid && prev_ov) begin
         chk("held_output", {16'b0, mult_high, mult_low}, {16'b0, held});
      end
      prev_ov = out_valid;
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit s, input bit track);
      int n = 0;
      exp_t e;
      @(negedge clk);
      a = x;
      b = y;
      do_signed = s;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", {31'b0, in_ready}, 32'd1);
      end else if (track) begin
         e.prod    = ref_prod(x, y, s);
         e.acc_cyc = cyc + 1;
         e.lat     = ref_lat(y, s);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      do_signed = 1'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("idle_timeout", {31'b0, in_ready}, 32'd1);
   endtask

   logic [W-1:0] va[12] = '{8'd3, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'd7, 8'd7, 8'h80, 8'h00, 8'h5A};
   logic [W-1:0] vb[12] = '{8'd5, 8'h01, 8'h01, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h7F, 8'hC3, 8'h80};
   bit           vs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_product", {16'b0, mult_high, mult_low}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) send(va[i], vb[i], vs[i], 1'b1);
      wait_idle();

      // Hold the product in DONE while a second request waits.
      rdy_force = 1'b0;
      send(8'd9, 8'd11, 1'b0, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("stall_reached_done", {31'b0, out_valid}, 32'd1);
      end
      a = 8'hF6;
      b = 8'h0D;
      do_signed = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      end
      rdy_force = 1'b1;
      send(8'hF6, 8'h0D, 1'b1, 1'b1);
      wait_idle();
      @(negedge clk);
      wait_idle();

      // cancel has priority over in_valid in IDLE.
      @(negedge clk);
      a = 8'd4;
      b = 8'd4;
      in_valid = 1'b1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_cancel_in_ready", {31'b0, in_ready}, 32'd1);
      chk("idle_cancel_busy", {31'b0, busy}, 32'd0);
      in_valid = 1'b0;
      cancel = 1'b0;

      // cancel three cycles into RUN: no product, outputs keep last value.
      send(8'd200, 8'd201, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      chk("cancel_in_ready", {31'b0, in_ready}, 32'd1);
      chk("cancel_busy", {31'b0, busy}, 32'd0);
      chk("cancel_out_valid", {31'b0, out_valid}, 32'd0);
      chk("cancel_retained", {16'b0, mult_high, mult_low}, {16'b0, last_prod});
      repeat (W + 3) @(negedge clk);

      // Asynchronous reset mid-RUN.
      send(8'd77, 8'd99, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_product", {16'b0, mult_high, mult_low}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (W + 3) @(negedge clk);

      // Random traffic with random back-pressure.
      rdy_rand = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] x, y;
         x = W'($urandom);
         y = W'($urandom);
         case ($urandom_range(0, 7))
            0: x = 8'h80;
            1: y = 8'h80;
            2: y = 8'h00;
            3: x = 8'hFF;
            default: ;
         endcase
         send(x, y, 1'($urandom), 1'b1);
      end

      begin
         int n = 0;
         while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (sb.size() != 0) chk("drain", sb.size(), 32'd0);
      end
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iter_mult.md
Name: iter_mult

Overview:
- Multi-cycle shift-add integer multiplier. Successor to the single-cycle combinational multiplier; trades latency for area.
- Operand width is parametrised. Produces a full 2*WIDTH product split into high and low halves, signed or unsigned per request.
- Valid/ready handshake on input and output; sits behind the ALU/execute-stage issue logic for MUL/SMULH/UMULH-class ops.
- One operation in flight at a time.

Parameters:
- WIDTH, 64, operand width in bits (legal: 4..64).
- CNT_W, $clog2(WIDTH), width of the internal iteration counter (derived; do not override).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- do_signed  input  1  1: two's-complement multiply, 0: unsigned.
- cancel  input  1  abort the current operation, return to IDLE.
- out_valid  output  1  product available (high only in DONE).
- out_ready  input  1  consumer takes the product.
- mult_low  output  WIDTH  product bits [WIDTH-1:0].
- mult_high  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, mult_low=mult_high=0, counter=0.
- IDLE, on in_valid:
  - Capture magnitudes |a| and |b|. Magnitude is the operand itself when do_signed=0 or the operand is non-negative.
  - Capture neg = do_signed & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator and counter; go to RUN.
- RUN, each edge:
  - If the multiplier LSB is 1, add the multiplicand (shifted left by the counter) into the accumulator.
  - Shift the multiplier right by 1; counter += 1.
  - On the edge where counter==WIDTH-1: go to DONE, load {mult_high,mult_low} = neg ? -acc_next : acc_next (2*WIDTH wide, wrap-around two's-complement negate).
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Magnitude of the most-negative operand (-2^(WIDTH-1)) is 2^(WIDTH-1), held as unsigned WIDTH bits; no overflow is possible in the 2*WIDTH accumulator.
- DONE:
  - out_valid=1; outputs held stable until an edge with out_ready=1, which returns the block to IDLE.
  - in_ready is 0 in DONE, so there is no accept in the same cycle as the output handshake. Back-to-back throughput is one op per WIDTH+2 cycles.
- cancel:
  - In RUN or DONE: next edge goes to IDLE, out_valid=0, outputs retain their last value.
  - In IDLE: ignored, and cancel has priority over in_valid (no accept that cycle).
- in_valid while not in IDLE: ignored, since in_ready=0.
- Operands and do_signed are sampled only at accept; later input changes do not affect the operation.
- reset_n asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro ITER_MULT_EARLY_TERM_EN.
- With the macro defined: in RUN, also go to DONE on any edge where the shifted multiplier becomes zero. Latency becomes max(1, index of highest set bit of |b| + 1); b=0 gives 1 cycle. The result is identical to the full-latency case.
- Without the macro: fixed latency of WIDTH cycles regardless of operand values.

Test Plan (WIDTH=8, macro undefined unless stated):
- a=3, b=5, do_signed=0 -> out_valid 8 edges after accept, mult_high=0x00, mult_low=0x0F.
- a=0xFF, b=0x01, do_signed=1 (-1*1) -> {mult_high,mult_low}=0xFFFF; same operands with do_signed=0 -> 0x00FF.
- a=0x80, b=0x80, signed -> 0x4000; unsigned -> 0x4000; a=0xFF, b=0xFF, unsigned -> 0xFE01, signed -> 0x0001.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0, second in_valid not accepted; release -> IDLE, next request accepted.
- cancel asserted 3 cycles into RUN -> IDLE next edge, out_valid never asserts; reset_n pulsed low mid-RUN -> all outputs at reset values immediately.
- With ITER_MULT_EARLY_TERM_EN: a=7, b=0x03 -> out_valid 2 edges after accept, result 0x0015; b=0 -> 1 edge, result 0x0000.
